// File: rtl/shift_add_mul8_pkg.sv
// shift_add_mul8_pkg: shared widths and state encodings for the multiplier and its bench
package shift_add_mul8_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int PW    = 2 * WIDTH;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/shift_add_mul8_adder.sv
// adder_16bit: gate-level 16-bit ripple-carry adder exposing every stage carry
module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic [15:0] c
);

    logic [16:0] cy;

    assign cy[0] = cin;

    genvar i;
    generate
        for (i = 0; i < 16; i++) begin : g_fa
            assign s[i]    = a[i] ^ b[i] ^ cy[i];
            assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
            assign c[i]    = cy[i+1];
        end
    endgenerate

endmodule

// File: rtl/shift_add_mul8.sv
// shift_add_mul8: sequential 8x8 unsigned shift-and-add multiplier, fixed 8-iteration run
module shift_add_mul8
    import shift_add_mul8_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [PW-1:0]    product
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    product_q, product_d;
    logic [PW-1:0]    sum_w;
    logic [PW-1:0]    carry_w;

    adder_16bit u_adder (
        .a   (acc_q),
        .b   (mcand_q),
        .cin (1'b0),
        .s   (sum_w),
        .c   (carry_w)
    );

    // Next-state: accept in IDLE, one shift/accumulate step per RUN cycle, DONE returns to IDLE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;
        if (state_q == ST_IDLE && start) begin
            state_d   = ST_RUN;
            cnt_d     = '0;
            mcand_d   = {{WIDTH{1'b0}}, a};
            mplier_d  = b;
            acc_d     = '0;
            product_d = '0;
        end else if (state_q == ST_RUN) begin
            acc_d    = mplier_q[0] ? sum_w : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                state_d   = ST_DONE;
                product_d = acc_d;
            end
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    // State registers; reset aborts any operation in flight without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            if (state_q == ST_RUN)
                assert (!carry_w[PW-1]) else $error("adder carry out of bit 15 during RUN");
        end
    end

    assign busy    = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mul8.sv
// tb_shift_add_mul8: directed vectors with hand-computed products, latency and handshake checks
module tb_shift_add_mul8;
    import shift_add_mul8_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_checks = 0;
    int n_fail = 0;
    int carry_hits = 0;

    shift_add_mul8 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    // Watch the adder final carry while iterating
    always @(posedge clk) begin
        if (dut.state_q == ST_RUN && dut.carry_w[15])
            carry_hits++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic [15:0] exp,
                          input bit ign_run, input bit ign_done, input string tag);
        int cyc;
        cyc = 0;
        a = oa;
        b = ob;
        start = 1'b1;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check({tag, "_busy"}, 32'(busy), 32'd1);
                check({tag, "_clr"}, 32'(product), 32'd0);
                start = 1'b0;
            end
            if (ign_run && cyc == 3) begin
                a = 8'hFF;
                b = 8'hFF;
                start = 1'b1;
            end
            if (ign_run && cyc == 4) begin
                start = 1'b0;
                a = 8'h77;
                b = 8'h66;
            end
            if (done) break;
        end
        check({tag, "_lat"}, 32'(cyc), 32'd9);
        check({tag, "_prod"}, 32'(product), 32'(exp));
        check({tag, "_dbusy"}, 32'(busy), 32'd1);
        if (ign_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_hold"}, 32'(product), 32'(exp));
        check({tag, "_stay"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int pulses;
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_prod", 32'(product), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        run_op(8'h0D, 8'h0B, 16'h008F, 1'b0, 1'b0, "m0d0b");
        run_op(8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, "mffff");
        run_op(8'h00, 8'hFF, 16'h0000, 1'b0, 1'b0, "m00ff");
        run_op(8'hA5, 8'h00, 16'h0000, 1'b0, 1'b0, "ma500");
        run_op(8'h12, 8'h34, 16'h03A8, 1'b1, 1'b1, "m1234");
        run_op(8'h0D, 8'h0B, 16'h008F, 1'b0, 1'b0, "again");

        a = 8'h37;
        b = 8'h59;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("ab_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ab_busy0", 32'(busy), 32'd0);
        check("ab_prod0", 32'(product), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("ab_nodone", 32'(pulses), 32'd0);
        run_op(8'h37, 8'h59, 16'h131F, 1'b0, 1'b0, "m3759");

        check("carry15", 32'(carry_hits), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
